// File: rtl/prf_keystream_ctrl_if.sv
// Bundle of the command, PRF-core and output-stream signals of prf_keystream_ctrl.
//
// Handshake rules, shared by both valid/ready pairs in this bundle:
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   Once the source raises valid, it keeps valid and every payload signal
//   stable until that transfer edge. The sink may raise or lower ready at any
//   time, and ready never depends combinationally on valid.
//   cmd_*  : the controller is the sink; cmd_ready is high only while idle.
//   m_*    : the controller is the source; m_last marks the final word.
// prf_start/prf_done are single-cycle pulses, not a valid/ready pair.
//
// Modports: master = the controller, slave = its environment (command
// issuer, PRF core, and downstream consumer seen as one).
interface prf_keystream_ctrl_if #(
  parameter int OUT_WIDTH  = 5,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  // command request
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [63:0]           cmd_nonce;
  logic [63:0]           cmd_base_index;
  logic [CNT_WIDTH-1:0]  cmd_count;

  // PRF core
  logic                  prf_start;
  logic [63:0]           prf_nonce;
  logic [63:0]           prf_index;
  logic [OUT_WIDTH-1:0]  prf_out;
  logic                  prf_done;

  // output word stream
  logic                  m_valid;
  logic                  m_ready;
  logic [WORD_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  cmd_valid, cmd_nonce, cmd_base_index, cmd_count,
    output cmd_ready,
    output prf_start, prf_nonce, prf_index,
    input  prf_out, prf_done,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    output cmd_valid, cmd_nonce, cmd_base_index, cmd_count,
    input  cmd_ready,
    input  prf_start, prf_nonce, prf_index,
    output prf_out, prf_done,
    input  m_valid, m_data, m_last,
    output m_ready
  );
endinterface

// File: rtl/prf_keystream_ctrl.sv
// prf_keystream_ctrl: command-side initiator for the PRF evaluation core.
// A command (nonce, base index, count) is turned into one core evaluation per
// sample; the results are packed LSB-first, SPW samples per word, and sent on
// the m_* stream with m_last on the final word, followed by a cmd_done pulse.
//
// Optional build macro PRF_TIMEOUT_EN: adds a watchdog on the WAIT state.
// If the core has not answered after TIMEOUT_CYCLES cycles, err is set
// (sticky until rst), the partial pack is flushed as the last word and the
// command ends. Without the macro err is tied low and WAIT never expires.
//
// state_dbg exposes the FSM state: 0=IDLE 1=ISSUE 2=WAIT 3=EMIT.
module prf_keystream_ctrl #(
  parameter int P              = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  prf_keystream_ctrl_if.master  bus,
  output logic                  cmd_done,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  localparam int OUT_WIDTH = $clog2(P);
  localparam int SPW       = WORD_WIDTH / OUT_WIDTH;
  localparam int SLOT_W    = $clog2(SPW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [SLOT_W-1:0]     slot;
  logic [WORD_WIDTH-1:0] pack;
  logic [WORD_WIDTH-1:0] pack_merged;
  logic                  word_full;
  logic                  last_sample;

  logic                  prf_start_q;
  logic [63:0]           prf_nonce_q;
  logic [63:0]           prf_index_q;
  logic                  m_valid_q;
  logic [WORD_WIDTH-1:0] m_data_q;
  logic                  m_last_q;
  logic                  cmd_done_q;

`ifdef PRF_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]       wd_cnt;
  logic                  err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.cmd_ready = (state == IDLE);
  assign bus.prf_start = prf_start_q;
  assign bus.prf_nonce = prf_nonce_q;
  assign bus.prf_index = prf_index_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_last    = m_last_q;
  assign cmd_done      = cmd_done_q;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

  // The incoming sample completes a word when it lands in the top slot, and
  // ends the command when it is the last one still owed.
  assign word_full   = (slot == SLOT_W'(SPW - 1));
  assign last_sample = (remaining == CNT_WIDTH'(1));

  // Current pack with prf_out dropped into slot k; slots are written once
  // each and cleared together, so untouched bits stay zero.
  always_comb begin
    pack_merged = pack;
    for (int k = 0; k < SPW; k++) begin
      if (slot == SLOT_W'(k)) begin
        pack_merged[k*OUT_WIDTH +: OUT_WIDTH] = bus.prf_out;
      end
    end
  end

  // Command FSM with all outputs registered; prf_start and cmd_done default
  // low every cycle so they can only ever be single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      slot        <= '0;
      pack        <= '0;
      prf_start_q <= 1'b0;
      prf_nonce_q <= '0;
      prf_index_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      cmd_done_q  <= 1'b0;
`ifdef PRF_TIMEOUT_EN
      wd_cnt      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      prf_start_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            prf_nonce_q <= bus.cmd_nonce;
            prf_index_q <= bus.cmd_base_index;
            remaining   <= bus.cmd_count;
            if (bus.cmd_count == '0) begin
              // empty command: acknowledge without touching the core
              cmd_done_q <= 1'b1;
            end else begin
              state       <= ISSUE;
              prf_start_q <= 1'b1;
            end
          end
        end

        ISSUE: begin
          // prf_start is high for exactly this cycle
          state <= WAIT;
`ifdef PRF_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end

        WAIT: begin
          if (bus.prf_done) begin
            pack        <= pack_merged;
            slot        <= slot + 1'b1;
            remaining   <= remaining - 1'b1;
            prf_index_q <= prf_index_q + 64'd1;
            if (word_full || last_sample) begin
              m_data_q  <= pack_merged;
              m_valid_q <= 1'b1;
              m_last_q  <= last_sample;
              state     <= EMIT;
            end else begin
              state       <= ISSUE;
              prf_start_q <= 1'b1;
            end
          end
`ifdef PRF_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            // core is presumed dead: flush what we have and end the command
            err_q     <= 1'b1;
            m_data_q  <= pack;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b1;
            state     <= EMIT;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        EMIT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            pack      <= '0;
            slot      <= '0;
            if (m_last_q) begin
              m_last_q   <= 1'b0;
              cmd_done_q <= 1'b1;
              state      <= IDLE;
            end else begin
              state       <= ISSUE;
              prf_start_q <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/prf_keystream_ctrl.md
Name: prf_keystream_ctrl

Overview:
- Command-side initiator for the PRF evaluation core.
- Accepts a keystream request (nonce, base index, sample count).
- Drives the core's start/nonce/index inputs once per sample, collects each prf_out on done, and packs the samples into words.
- Emits the words on a valid/ready stream toward the downstream consumer.

Parameters:
- P, 32, PRF output modulus; OUT_WIDTH = $clog2(P) = 5.
- WORD_WIDTH, 32, width of output stream words; SPW = WORD_WIDTH / OUT_WIDTH samples per word (6 at defaults).
- CNT_WIDTH, 16, width of sample-count field.
- TIMEOUT_CYCLES, 4096, watchdog limit, used only with PRF_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_nonce  in  64  nonce for the whole command.
- cmd_base_index  in  64  index of the first sample.
- cmd_count  in  CNT_WIDTH  number of PRF samples requested.
- prf_start  out  1  one-cycle pulse to the core.
- prf_nonce  out  64  registered nonce to the core.
- prf_index  out  64  registered index to the core.
- prf_out  in  OUT_WIDTH  core result, sampled when prf_done=1.
- prf_done  in  1  one-cycle completion pulse from the core.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  WORD_WIDTH  packed samples.
- m_last  out  1  final word of the command.
- cmd_done  out  1  one-cycle pulse when the command completes.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  sticky watchdog flag (PRF_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - Outputs: cmd_ready=1, prf_start=0, prf_nonce=0, prf_index=0, m_valid=0, m_data=0, m_last=0, cmd_done=0, busy=0, err=0.
  - Internal pack slot counter, remaining count and pack register cleared.
  - Reset mid-command abandons the command silently; the core shares the same reset.
- States: IDLE, ISSUE, WAIT, EMIT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch nonce into prf_nonce, base index into prf_index, count into remaining.
  - If count=0: pulse cmd_done the next cycle, stay in IDLE, produce no word.
  - Otherwise go to ISSUE.
- ISSUE:
  - Assert prf_start for exactly one cycle, then go to WAIT.
  - prf_nonce/prf_index are held stable from this cycle until prf_done.
- WAIT:
  - On prf_done: write prf_out into pack slot k at bits [k*OUT_WIDTH +: OUT_WIDTH] (first sample at LSB).
  - Decrement remaining; prf_index <= prf_index+1 (64-bit wrap, all-ones -> 0).
  - If the slot becomes SPW, or remaining reaches 0: load m_data, set m_valid=1, set m_last=(remaining==0), go to EMIT.
  - Else go to ISSUE.
  - prf_done outside WAIT is ignored.
- EMIT:
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
  - No prf_start is issued in EMIT.
  - On m_ready: m_valid=0, pack register and slot cleared.
  - If m_last: pulse cmd_done, go to IDLE. Else go to ISSUE.
- Partial final word: unused slots and the upper WORD_WIDTH - SPW*OUT_WIDTH bits are zero.
- Throughput: one sample per (core latency + 2) cycles; one extra cycle per word, plus any backpressure.
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
- Macro PRF_TIMEOUT_EN.
- When defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES before prf_done: err is set (sticky until rst), the current pack contents are emitted with m_last=1 via EMIT, then cmd_done pulses.
- When undefined: no counter, err is tied 0, and WAIT lasts indefinitely.

Test Plan:
- Reset: assert rst for 2 cycles mid-WAIT -> next cycle m_valid=0, busy=0, cmd_ready=1; a later command runs normally.
- nonce=0x1, base=0, count=6, core returns 1..6 -> exactly 6 prf_start pulses with prf_index 0..5; one word m_data=0x0C520C41 (slots 1,2,3,4,5,6 LSB-first), m_last=1, then cmd_done.
- count=7 -> two words; second word = sample7 in bits[4:0], all other bits 0, m_last=1; first word has m_last=0.
- Backpressure: hold m_ready=0 for 10 cycles during EMIT -> m_data stable, no prf_start pulses until the cycle after m_ready=1.
- base=0xFFFFFFFFFFFFFFFF, count=2 -> prf_index sequence FFFFFFFFFFFFFFFF then 0000000000000000.
- count=0 -> cmd_done one cycle after accept, no prf_start, m_valid never asserted.
- PRF_TIMEOUT_EN, TIMEOUT_CYCLES=16, core never returns done -> err=1 after 16 WAIT cycles; one word with m_last=1 and zero data; cmd_done pulses.
